// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: host byte FIFO sequencing bytes into the UART transmitter's load/ready/start handshake.
// Define UART_TX_FEEDER_IFG_EN to stretch each frame by IFG_CYCLES idle cycles.
module uart_tx_feeder #(
  parameter int ADDR_W = 3,
  parameter int FRAME_CYCLES = 10,
  parameter int IFG_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        data_bus,
  output logic              ld_tx_datareg,
  output logic              byte_ready,
  output logic              t_byte
);
`ifdef UART_TX_FEEDER_IFG_EN
  localparam bit IFG_EN = 1'b1;
`else
  localparam bit IFG_EN = 1'b0;
`endif
  localparam int WAIT_LEN = FRAME_CYCLES + (IFG_EN ? IFG_CYCLES : 0);
  localparam int CW = $clog2(WAIT_LEN + 1);
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    READY = 5'b00100,
    START = 5'b01000,
    WAIT  = 5'b10000
  } state_t;
  state_t              state;
  logic [7:0]          mem [2**ADDR_W];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt;
  logic                push, pop, wait_end;
  assign full     = count[ADDR_W];
  assign empty    = count == '0;
  assign busy     = state != IDLE || !empty;
  assign push     = wr_en && !full;
  assign pop      = state == IDLE && !empty;
  assign wait_end = state == WAIT && cnt == CW'(WAIT_LEN - 1);
  always_ff @(posedge clk)
    if (push && !reset_) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (reset_) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cnt           <= '0;
      state         <= IDLE;
      overflow      <= 1'b0;
      frame_done    <= 1'b0;
      data_bus      <= '0;
      ld_tx_datareg <= 1'b0;
      byte_ready    <= 1'b0;
      t_byte        <= 1'b0;
    end else begin
      overflow      <= wr_en && full;
      wr_ptr        <= wr_ptr + ADDR_W'(push);
      rd_ptr        <= rd_ptr + ADDR_W'(pop);
      count         <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      ld_tx_datareg <= pop;
      byte_ready    <= state == LOAD;
      t_byte        <= state == READY;
      frame_done    <= wait_end;
      cnt           <= state == WAIT ? cnt + CW'(1) : '0;
      if (pop) data_bus <= mem[rd_ptr];
      state <= state == IDLE  ? (empty ? IDLE : LOAD) :
               state == LOAD  ? READY :
               state == READY ? START :
               state == START ? WAIT  :
               wait_end       ? IDLE  : WAIT;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scoreboard bench for uart_tx_feeder against a queue-and-timer reference model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int FRAME = 10;
`ifdef UART_TX_FEEDER_IFG_EN
  localparam int IFG = 2;
`else
  localparam int IFG = 0;
`endif
  localparam int SPACING = 4 + FRAME + IFG;
  logic clk = 0, reset_ = 1, wr_en = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, busy, frame_done, ld_tx_datareg, byte_ready, t_byte;
  logic [3:0] count;
  logic [7:0] data_bus;
  uart_tx_feeder dut (
    .clk(clk), .reset_(reset_), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .frame_done(frame_done), .data_bus(data_bus),
    .ld_tx_datareg(ld_tx_datareg), .byte_ready(byte_ready), .t_byte(t_byte)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] data; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] mq[$];
  int timer = 0, cyc = 0, passes = 0, total = 0, k = 0;
  logic rst_q = 0, ov_m = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask
  // Model: bytes leave in write order; a pop may occur only SPACING edges after the previous one.
  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    wr_data = d;
    reset_ = r;
    if (r) begin
      mq.delete();
      exp_q.delete();
      timer = 0;
      ov_m = 0;
    end else begin
      ov_m = w && mq.size() == DEPTH;
      if (timer > 0) timer--;
      else if (mq.size() > 0) begin
        exp_q.push_back('{mq.pop_front(), cyc + 1});
        timer = SPACING - 1;
      end
      if (w && !ov_m) mq.push_back(d);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("count", count, mq.size());
    chk("full_empty_busy_ovf", {full, empty, busy, overflow},
        {mq.size() == DEPTH, mq.size() == 0, timer > 0 || mq.size() > 0, ov_m});
  endtask
  always @(posedge clk) rst_q <= reset_;
  always @(negedge clk) begin
    if (rst_q) begin
      k = 0;
      chk("reset_outputs", {ld_tx_datareg, byte_ready, t_byte, frame_done, data_bus}, 0);
    end else if (k == 0) begin
      if (ld_tx_datareg) begin
        chk("ld_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ld_data", data_bus, e.data);
          chk("ld_cycle", cyc, e.cyc);
        end
        k = 1;
        bad = 0;
      end else chk("idle_strobes", {byte_ready, t_byte, frame_done}, 0);
    end else begin
      bad |= ld_tx_datareg || byte_ready != (k == 1) || t_byte != (k == 2) || frame_done != (k == SPACING - 1);
      if (k == SPACING - 1) begin
        chk("strobe_seq", bad, 0);
        k = 0;
      end else k++;
    end
  end
  initial begin
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(1, 8'hA5, 0);
    repeat (20) tick(0, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0);
    repeat (9 * SPACING + 10) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 8'h30 + 8'(i), 0);
    repeat (5) tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (20) tick(0, 0, 0);
    tick(1, 8'h55, 1);
    repeat (3) tick(0, 0, 0);
    for (int i = 0; i < 1500; i++) tick($urandom_range(0, 99) < 20, 8'($urandom), 0);
    repeat (12 * SPACING) tick(0, 0, 0);
    chk("drained", exp_q.size() + mq.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Host-side buffer and sequencer directly upstream of the UART transmitter.
- Accepts bytes from the host into a small FIFO, then presents each byte to the transmitter using its load/ready/start protocol:
  - data_bus + ld_tx_datareg
  - byte_ready
  - t_byte
- Waits out the transmitter's frame time before issuing the next byte, so the transmitter is only ever offered a byte in its idle state.
- Shares the transmitter's bit clock.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W (8 entries).
- FRAME_CYCLES, 10, cycles spent in WAIT after t_byte: 9 shift cycles + 1 clear cycle of the transmitter.
- IFG_CYCLES, 2, extra idle cycles per frame; used only with the optional feature.

Ports:
- clk  input  1  bit clock, same clock as the transmitter.
- reset_  input  1  synchronous, active-high reset.
- wr_en  input  1  host write strobe.
- wr_data  input  8  host byte.
- full  output  1  FIFO holds 2**ADDR_W entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  FIFO occupancy.
- overflow  output  1  one-cycle pulse when a write is rejected.
- busy  output  1  high when state != IDLE or empty == 0.
- frame_done  output  1  one-cycle pulse when WAIT completes.
- data_bus  output  8  byte to the transmitter.
- ld_tx_datareg  output  1  transmitter data-register load strobe.
- byte_ready  output  1  transmitter byte-ready strobe.
- t_byte  output  1  transmitter start strobe.

Behaviour:
- Reset and registers
  - All state changes on posedge clk.
  - reset_=1 at an edge clears: rd/wr pointers, count (0), state (IDLE), WAIT counter, all strobes, data_bus, overflow, frame_done. FIFO storage is not cleared.
  - Reset outputs: empty=1, full=0, busy=0.
  - Reset mid-frame aborts the sequence immediately and drops all buffered bytes. The system resets the transmitter in the same cycle.
  - All outputs are registered except full, empty and busy, which are decoded from registered state.
- FIFO
  - Write: wr_en=1 and full=0 stores wr_data at wr_ptr, wr_ptr++.
  - Rejected write: wr_en=1 and full=1 drops the byte and pulses overflow for the next cycle. This applies even if a pop occurs in the same cycle (full is evaluated before the pop).
  - Pop occurs only on the IDLE->LOAD transition.
  - Simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo 2**ADDR_W; count is ADDR_W+1 bits wide.
- State machine (one-hot: IDLE, LOAD, READY, START, WAIT)
  - IDLE: if empty=0, at the edge: data_bus<=FIFO[rd_ptr], rd_ptr++, ld_tx_datareg<=1, ->LOAD. Otherwise stay.
  - LOAD (ld_tx_datareg=1 this cycle): ld_tx_datareg<=0, byte_ready<=1, ->READY.
  - READY (byte_ready=1 this cycle): byte_ready<=0, t_byte<=1, ->START.
  - START (t_byte=1 this cycle): t_byte<=0, cnt<=0, ->WAIT.
  - WAIT: cnt++ each cycle. When cnt==FRAME_CYCLES-1: frame_done<=1, ->IDLE.
  - Each strobe is high for exactly one cycle.
  - data_bus holds its value from the LOAD cycle until the next pop.
- Latency
  - Write accepted at edge E0 with the FIFO empty and state IDLE.
  - ld_tx_datareg high in the cycle after E1.
  - byte_ready high after E2.
  - t_byte high after E3.
  - Transmitter start bit appears after E4.
  - frame_done pulses after E14.
- Throughput: back-to-back bytes are spaced 4+FRAME_CYCLES = 14 cycles apart (strobe to strobe).
- A write arriving during LOAD..WAIT is buffered and is not popped before IDLE.

Optional Feature:
- Macro: UART_TX_FEEDER_IFG_EN.
- Defined: WAIT ends at cnt==FRAME_CYCLES+IFG_CYCLES-1. The transmitter line stays at 1 for IFG_CYCLES extra cycles between frames. Frame spacing becomes 16 cycles at defaults.
- Undefined: WAIT is exactly FRAME_CYCLES. IFG_CYCLES is ignored.

Test Plan:
- Single byte, 0xA5 written at E0 -> required response:
  - ld_tx_datareg pulses after E1 with data_bus=0xA5.
  - byte_ready pulses after E2.
  - t_byte pulses after E3.
  - Transmitter serial sequence: 0, 1,0,1,0,0,1,0,1, then 1.
  - frame_done pulses after E14; busy returns to 0.
- Burst of 9 writes 0x00..0x08 on consecutive cycles while state is IDLE:
  - The first byte is popped.
  - The remaining 8 fill the FIFO; full=1.
  - No overflow occurs.
  - All 9 bytes are transmitted in order, ld strobes 14 cycles apart.
- Full FIFO, wr_en=1 on the same edge as the IDLE->LOAD pop -> byte rejected, overflow=1 for one cycle, count goes from 8 to 7.
- reset_=1 for one cycle during WAIT with 3 bytes queued -> required response:
  - Next cycle: empty=1, count=0, all strobes 0, state IDLE.
  - No further ld_tx_datareg until a new write.
- Reset released, then wr_en=1 with reset_=1 held on the same edge -> write ignored, empty stays 1.
- UART_TX_FEEDER_IFG_EN defined with IFG_CYCLES=2, two bytes queued -> ld_tx_datareg pulses 16 cycles apart, serial line 1 during the gap.
